dmem_responder: RTL

Data-memory responder for the pipeline's MEM-stage load/store port. It accepts one request at a time over a valid/ready handshake and models a configurable access latency. It performs little-endian byte/half/word lane steering with sign or zero extension on loads, and returns a single-cycle response pulse. It is the slave end of the interface that the MEM stage drives with dmem_wena/dmem_rena, load/store selects and the computed address.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and the default base.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte-enables/replicated write word, load extract and extend.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata
);

   logic [1:0]  eff_lane;
   logic [31:0] shifted;

   // Half and word accesses are forced to their natural boundary; faulting is decided upstream.
   always_comb begin
      be       = 4'b0000;
      wword    = wdata;
      eff_lane = lane;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            eff_lane = {lane[1], 1'b0};
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wword    = {2{wdata[15:0]}};
         end
         SZ_WORD: begin
            eff_lane = 2'b00;
            be       = 4'b1111;
         end
         default: ;
      endcase
   end

   assign shifted = rword >> {eff_lane, 3'b000};

   always_comb begin
      rdata = '0;
      case (size)
         SZ_BYTE: rdata = {{24{sign & shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata = {{16{sign & shifted[15]}}, shifted[15:0]};
         SZ_WORD: rdata = shifted;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with configurable wait latency and single-cycle response pulse.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word requests instead of aligning them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_sign_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, sign_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] mem [DEPTH_WORDS];

   logic        sel_we, sel_sign;
   logic [31:0] sel_addr, sel_wdata;
   logic [1:0]  sel_size;
   logic [31:0] offset;
   logic [AW-1:0] idx;
   logic [1:0]  lane;
   logic        misalign, fault, commit;
   logic [3:0]  be;
   logic [31:0] wword, ldata, rword;

   // With zero wait the request is served on its acceptance edge, so bypass the capture registers.
   always_comb begin
      if (state_q == StIdle) begin
         sel_we    = req_we_i;
         sel_addr  = req_addr_i;
         sel_wdata = req_wdata_i;
         sel_size  = req_size_i;
         sel_sign  = req_sign_i;
      end else begin
         sel_we    = we_q;
         sel_addr  = addr_q;
         sel_wdata = wdata_q;
         sel_size  = size_q;
         sel_sign  = sign_q;
      end
   end

   assign offset = sel_addr - BASE_ADDR;
   assign idx    = offset[AW+1:2];
   assign lane   = offset[1:0];
   assign rword  = mem[idx];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = ((sel_size == SZ_HALF) && lane[0]) ||
                     ((sel_size == SZ_WORD) && (lane != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign fault = (sel_size == SZ_ILL) || ({1'b0, offset} >= LIMIT) || misalign;

   dmem_lane_align u_align (
      .size  (sel_size),
      .lane  (lane),
      .sign  (sel_sign),
      .wdata (sel_wdata),
      .rword (rword),
      .be    (be),
      .wword (wword),
      .rdata (ldata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = StResp;
                  commit  = 1'b1;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = fault;
         rdata_d = (fault || sel_we) ? 32'd0 : ldata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == StIdle && req_valid_i) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= req_size_i;
            sign_q  <= req_sign_i;
         end
      end
   end

   // Array is deliberately not reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (commit && rst && sel_we && !fault) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign rsp_valid_o = (state_q == StResp);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule
